// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, widths and FSM state encoding for the command-level SPI master.
package spi_cmd_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 4;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    RECV,
    END
  } state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for the SPI master: shared down-counter, MSB-first tx frame shifter
// and MSB-first rx byte assembler.
module spi_master_shifter
  import spi_cmd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  input  logic               shift_tx,
  output logic               tx_msb_c,
  input  logic               cnt_ld,
  input  logic [CNT_W-1:0]   cnt_val,
  input  logic               cnt_dec,
  output logic               cnt_zero_c,
  input  logic               rx_en,
  input  logic               miso,
  output logic [BYTE_W-1:0]  rx_byte_c
);

  logic [FRAME_W-1:0] tx_sr;
  logic [BYTE_W-2:0]  rx_sr;
  logic [CNT_W-1:0]   cnt;

  assign tx_msb_c   = tx_sr[FRAME_W-1];
  assign cnt_zero_c = (cnt == '0);
  // The byte completes on the same edge the last bit is sampled.
  assign rx_byte_c  = {rx_sr, miso};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sr <= '0;
      rx_sr <= '0;
      cnt   <= '0;
    end else begin
      if (load) begin
        tx_sr <= frame;
      end else if (shift_tx) begin
        tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
      end

      if (rx_en) begin
        rx_sr <= rx_byte_c[BYTE_W-2:0];
      end

      if (cnt_ld) begin
        cnt <= cnt_val;
      end else if (cnt_dec) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_master_cmd.sv
// Command-level SPI master: serialises 10-bit {op, payload} frames to the SPI
// slave RAM wrapper and returns the MISO byte for read-data commands.
module spi_master_cmd
  import spi_cmd_pkg::*;
#(
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        SS_n,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [CNT_W-1:0] SHIFT_INIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] RECV_INIT  = CNT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'(IDLE_GAP - 1);

  state_e             state;
  logic               is_rd;
  logic               accept;
  logic               shift_tx;
  logic               tx_msb_c;
  logic               cnt_ld;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_dec;
  logic               cnt_zero_c;
  logic [BYTE_W-1:0]  rx_byte_c;

  assign accept = cmd_valid && cmd_ready;

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .frame      ({cmd_op, cmd_data}),
    .shift_tx   (shift_tx),
    .tx_msb_c   (tx_msb_c),
    .cnt_ld     (cnt_ld),
    .cnt_val    (cnt_val),
    .cnt_dec    (cnt_dec),
    .cnt_zero_c (cnt_zero_c),
    .rx_en      (state == RECV),
    .miso       (MISO),
    .rx_byte_c  (rx_byte_c)
  );

  // Counter/shifter sequencing; the counter is reloaded on each phase change.
  always_comb begin
    shift_tx = 1'b0;
    cnt_ld   = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state)
      START: begin
        shift_tx = 1'b1;
        cnt_ld   = 1'b1;
        cnt_val  = SHIFT_INIT;
      end
      SHIFT: begin
        if (cnt_zero_c) begin
          cnt_ld  = 1'b1;
          cnt_val = is_rd ? WAIT_INIT : GAP_INIT;
        end else begin
          shift_tx = 1'b1;
          cnt_dec  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_zero_c) begin
          cnt_ld  = 1'b1;
          cnt_val = RECV_INIT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RECV: begin
        if (cnt_zero_c) begin
          cnt_ld  = 1'b1;
          cnt_val = GAP_INIT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      END: begin
        cnt_dec = !cnt_zero_c;
      end
      default: ;
    endcase
  end

  // FSM with registered pin outputs; MOSI carries frame[cnt] during SHIFT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_rd     <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= START;
            is_rd     <= (cmd_op == OP_RD_DATA);
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            SS_n      <= 1'b0;
            MOSI      <= cmd_op[1];
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        START: begin
          state <= SHIFT;
          MOSI  <= tx_msb_c;
        end
        SHIFT: begin
          if (cnt_zero_c) begin
            MOSI <= 1'b0;
            if (is_rd) begin
              state <= WAIT;
            end else begin
              state <= END;
              SS_n  <= 1'b1;
            end
          end else begin
            MOSI <= tx_msb_c;
          end
        end
        WAIT: begin
          if (cnt_zero_c) begin
            state <= RECV;
          end
        end
        RECV: begin
          if (cnt_zero_c) begin
            state     <= END;
            SS_n      <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_byte_c;
          end
        end
        END: begin
          if (cnt_zero_c) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_cmd.sv
// Directed bench for spi_master_cmd: default instance talks to a behavioural
// SPI slave RAM; a second instance with RD_WAIT=3, IDLE_GAP=2 gets MISO from the bench.
module tb_spi_master_cmd;

  logic       clk;
  logic       rst_n;

  logic       cmd_valid, cmd_ready, rsp_valid, busy, ss_n, mosi, miso;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, rsp_data;

  logic       cmd_valid2, cmd_ready2, rsp_valid2, busy2, ss_n2, mosi2, miso2;
  logic [1:0] cmd_op2;
  logic [7:0] cmd_data2, rsp_data2;

  int n_checks = 0;
  int n_fail   = 0;

  spi_master_cmd dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
  );

  spi_master_cmd #(.RD_WAIT(3), .IDLE_GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op2), .cmd_data(cmd_data2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .busy(busy2), .SS_n(ss_n2), .MOSI(mosi2), .MISO(miso2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave + RAM; MISO is 1 outside the read-data window.
  logic [7:0] mem [0:255];
  logic [7:0] s_wr_addr, s_rd_addr, s_tx;
  logic [8:0] s_sr;
  int         s_cnt;

  always @(posedge clk) begin
    if (!rst_n || ss_n) begin
      s_cnt <= 0;
      miso  <= 1'b1;
      if (!rst_n) begin
        s_wr_addr <= '0;
        s_rd_addr <= '0;
      end
    end else begin
      s_cnt <= s_cnt + 1;
      if (s_cnt >= 1 && s_cnt <= 9) s_sr <= {s_sr[7:0], mosi};
      if (s_cnt == 10) begin
        case (s_sr[8:7])
          2'b00:   s_wr_addr <= {s_sr[6:0], mosi};
          2'b01:   mem[s_wr_addr] <= {s_sr[6:0], mosi};
          2'b10:   s_rd_addr <= {s_sr[6:0], mosi};
          default: s_tx <= mem[s_rd_addr];
        endcase
      end
      miso <= (s_cnt >= 12 && s_cnt <= 19) ? s_tx[3'(19 - s_cnt)] : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic ss_log [0:63];
  logic mosi_log [0:63];
  logic busy_log [0:63];
  int   lat, rv_cnt, rv_pos;
  logic [7:0] rv_dat;

  // Log index e holds outputs registered at the e-th edge after the accept edge.
  function automatic logic [31:0] pack(input int which, input int first, input int n);
    logic [31:0] v = '0;
    for (int e = first; e < first + n; e++) begin
      logic b;
      b = (which == 0) ? ss_log[e] : (which == 1) ? mosi_log[e] : busy_log[e];
      v = {v[30:0], b};
    end
    return v;
  endfunction

  task automatic run_cmd(input int sel, input logic [1:0] op, input logic [7:0] data,
                         input logic [7:0] rx);
    int k;
    lat = -1; rv_cnt = 0; rv_pos = -1; rv_dat = '0;
    @(negedge clk);
    k = 0;
    while (((sel == 0) ? !cmd_ready : !cmd_ready2) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sel == 0) begin cmd_valid = 1'b1; cmd_op = op; cmd_data = data; end
    else begin cmd_valid2 = 1'b1; cmd_op2 = op; cmd_data2 = data; end
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_valid2 = 1'b0;
      if (sel == 1) miso2 = (c >= 15 && c <= 22) ? rx[3'(22 - c)] : 1'b1;
      ss_log[c-1]   = (sel == 0) ? ss_n : ss_n2;
      mosi_log[c-1] = (sel == 0) ? mosi : mosi2;
      busy_log[c-1] = (sel == 0) ? busy : busy2;
      if ((sel == 0) ? rsp_valid : rsp_valid2) begin
        rv_cnt++;
        rv_pos = c - 1;
        rv_dat = (sel == 0) ? rsp_data : rsp_data2;
      end
      if ((sel == 0) ? cmd_ready : cmd_ready2) begin
        lat = c - 1;
        break;
      end
    end
    miso2 = 1'b1;
  endtask

  logic [9:0] q [0:2];

  initial begin
    int idx, frames, gap, min_gap, viol, rv;
    logic prev_ss, acc;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hC5;
    mem[8'h10] = 8'hFF;

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    cmd_valid2 = 1'b0; cmd_op2 = '0; cmd_data2 = '0; miso2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ss_n", 32'(ss_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rel_cmd_ready2", 32'(cmd_ready2), 32'd1);

    // Write-address frame
    run_cmd(0, 2'b00, 8'h3A, 8'h00);
    check("t1_latency", 32'(lat), 32'd12);
    check("t1_ss_n", pack(0, 0, 12), 32'h001);
    check("t1_mosi", pack(1, 0, 11), 32'h03A);
    check("t1_busy", pack(2, 0, 13), 32'h1FFE);
    check("t1_no_rsp", 32'(rv_cnt), 32'd0);

    // Read-data frame; slave returns mem[0]=C5
    run_cmd(0, 2'b11, 8'h00, 8'h00);
    check("t2_latency", 32'(lat), 32'd22);
    check("t2_ss_n", pack(0, 0, 22), 32'h1);
    check("t2_mosi", pack(1, 0, 11), 32'h700);
    check("t2_mosi_quiet", pack(1, 11, 11), 32'h0);
    check("t2_rsp_count", 32'(rv_cnt), 32'd1);
    check("t2_rsp_pos", 32'(rv_pos), 32'd21);
    check("t2_rsp_data", 32'(rv_dat), 32'hC5);

    // RAM round trip through the slave model
    run_cmd(0, 2'b00, 8'h10, 8'h00);
    check("t3_wa_latency", 32'(lat), 32'd12);
    run_cmd(0, 2'b01, 8'h5A, 8'h00);
    run_cmd(0, 2'b10, 8'h10, 8'h00);
    check("t3_ra_no_rsp", 32'(rv_cnt), 32'd0);
    run_cmd(0, 2'b11, 8'h00, 8'h00);
    check("t3_rsp_data", 32'(rv_dat), 32'h5A);
    check("t3_mem", 32'(mem[8'h10]), 32'h5A);

    // cmd_valid held high across three queued commands
    q[0] = {2'b00, 8'h20}; q[1] = {2'b01, 8'h77}; q[2] = {2'b10, 8'h20};
    @(negedge clk);
    idx = 0; frames = 0; gap = 99; min_gap = 99; viol = 0; prev_ss = 1'b1;
    cmd_valid = 1'b1; {cmd_op, cmd_data} = q[0];
    for (int k = 0; k < 80; k++) begin
      acc = cmd_valid && cmd_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) {cmd_op, cmd_data} = q[idx];
        else cmd_valid = 1'b0;
      end
      if (!ss_n && cmd_ready) viol++;
      if (prev_ss && !ss_n) begin
        frames++;
        if (frames > 1 && gap < min_gap) min_gap = gap;
      end
      gap = ss_n ? gap + 1 : 0;
      prev_ss = ss_n;
    end
    cmd_valid = 1'b0;
    check("t4_accepts", 32'(idx), 32'd3);
    check("t4_frames", 32'(frames), 32'd3);
    check("t4_min_gap", 32'(min_gap), 32'd2);
    check("t4_ready_in_frame", 32'(viol), 32'd0);
    check("t4_mem", 32'(mem[8'h20]), 32'h77);

    // Reset during the 5th SHIFT cycle of a read-data frame
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h00;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("t5_in_frame", 32'(ss_n), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_ss_n", 32'(ss_n), 32'd1);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rsp_data", 32'(rsp_data), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    rv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    check("t5_no_rsp", 32'(rv), 32'd0);
    run_cmd(0, 2'b11, 8'h00, 8'h00);
    check("t5_after_latency", 32'(lat), 32'd22);
    check("t5_after_rsp", 32'(rv_dat), 32'hC5);

    // RD_WAIT=3, IDLE_GAP=2 instance
    run_cmd(1, 2'b11, 8'hA5, 8'h96);
    check("t6_latency", 32'(lat), 32'd24);
    check("t6_ss_n", pack(0, 0, 24), 32'h3);
    check("t6_mosi", pack(1, 0, 11), 32'h7A5);
    check("t6_rsp_count", 32'(rv_cnt), 32'd1);
    check("t6_rsp_pos", 32'(rv_pos), 32'd22);
    check("t6_rsp_data", 32'(rv_dat), 32'h96);
    run_cmd(1, 2'b01, 8'h33, 8'h00);
    check("t6_wr_latency", 32'(lat), 32'd13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_cmd.md
Name: spi_master_cmd

Overview:
- Command-level SPI master that drives the SPI slave / single-port RAM wrapper (SS_n, MOSI, MISO) from a parallel valid/ready command interface.
- Serializes each 10-bit RAM command frame: 2-bit opcode plus 8-bit payload.
- For read-data commands, it captures the 8-bit byte returned on MISO and presents it on a response port.
- Sits directly upstream of the slave wrapper. It shares the slave's clk, which also serves as the SPI bit clock.

Parameters:
- RD_WAIT, 2, clk cycles after the last MOSI frame bit before the first MISO bit is sampled; covers slave RAM read plus turnaround.
- IDLE_GAP, 1, minimum cycles SS_n is held high between frames (range 1..15).

Ports:
- clk  in  1  system clock and SPI bit clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_op  in  2  opcode: 00 write addr, 01 write data, 10 read addr, 11 read data.
- cmd_data  in  8  payload (address or data); don't-care content for op 11, but still shifted.
- rsp_valid  out  1  one-cycle pulse; rsp_data holds the read byte.
- rsp_data  out  8  last byte received on MISO; holds until the next read-data completes.
- busy  out  1  high whenever state != IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (rst_n=0 at posedge) forces the following on the next edge:
  - state=IDLE
  - SS_n=1, MOSI=0
  - cmd_ready=0 during reset, 1 from the first cycle after release
  - rsp_valid=0, rsp_data=8'h00, busy=0
- Reset mid-frame: SS_n returns high on that edge, no rsp_valid, the partial frame is abandoned.
- All outputs are registered. The slave samples them at the following posedge.
- Handshake: accept when cmd_valid && cmd_ready at a posedge. Latch frame = {cmd_op, cmd_data} and go to START. While busy, cmd_valid is ignored.
- States and transitions:
  - IDLE: SS_n=1. On accept -> START.
  - START (1 cycle): SS_n=0, MOSI=frame[9] (command-select bit checked by the slave). -> SHIFT.
  - SHIFT (10 cycles): SS_n=0, MOSI=frame[9] down to frame[0], MSB first, driven by a 4-bit bit counter 9..0.
    - When the counter reaches 0: op==11 -> WAIT, else -> END.
  - WAIT (RD_WAIT cycles): SS_n=0, MOSI=0. -> RECV.
  - RECV (8 cycles): SS_n=0, MOSI=0. Shift MISO into rx_shift MSB first, one bit per cycle.
    - After the 8th bit: rsp_data <= assembled byte, rsp_valid=1 for exactly one cycle (the first END cycle). -> END.
  - END (IDLE_GAP cycles): SS_n=1, MOSI=0. -> IDLE, cmd_ready=1.
- Latency from accept edge to cmd_ready high:
  - ops 00/01/10: 1+10+IDLE_GAP cycles (12 at defaults).
  - op 11: 1+10+RD_WAIT+8+IDLE_GAP cycles (22 at defaults).
- Back-to-back: a command presented while cmd_ready rises is accepted on that edge. SS_n never stays low across two frames.
- MISO is sampled only in RECV. Glitches or X on MISO elsewhere have no effect.
- Read-address frames (op 10) produce no response. The slave's internal read-address/read-data sequencing is the user's responsibility.

Decomposition:
- Package spi_cmd_pkg holds:
  - opcode localparams OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11
  - FRAME_W=10, BYTE_W=8
  - state encoding (IDLE, START, SHIFT, WAIT, RECV, END)
- One sub-module: spi_master_shifter. It holds the bit counter, the tx shift register (load/shift, MSB first) and the rx shift register (capture, MSB first). The FSM stays in spi_master_cmd.

Test Plan:
1. Reset, then cmd op=00, data=8'h3A -> SS_n low for 11 cycles; MOSI = 0, then 0,0,0,0,1,1,1,0,1,0; SS_n high; cmd_ready back after 12 cycles; no rsp_valid.
2. MISO slave model returns 8'hC5 for op=11 (data 8'h00) -> MOSI = 1, then 1,1,0,0,0,0,0,0,0,0; rsp_valid pulses once with rsp_data=8'hC5, 22 cycles after accept.
3. Integration with the slave wrapper, RAM preloaded mem[8'h10]=8'hFF:
   - Sequence: op 00/10, op 01/8'h5A, op 10/8'h10, op 11.
   - Required: rsp_data=8'h5A; mem[8'h10]=8'h5A.
4. cmd_valid held high with three queued commands -> exactly three frames, each separated by ≥IDLE_GAP cycles of SS_n=1; cmd_ready low throughout each frame.
5. rst_n asserted on the 5th SHIFT cycle of an op=11 frame -> SS_n=1 on the next edge; no rsp_valid; rsp_data=8'h00; next command completes normally.
6. RD_WAIT=3, IDLE_GAP=2 -> read-data latency 24 cycles; MISO bit sampled at correspondingly shifted positions; rsp_data correct.
